me_search_ctrl: RTL and testbench

- Sequences the variable-block-size SAD array (vbs_me + sad_absolute) over a full search window for one 16x16 macroblock.
- Per candidate motion vector it generates row addresses and the array `sel` code, then waits out the pipeline latency.
- It keeps the running minimum SAD and its MV for the 9 partitions 16x16, 16x8(2), 8x16(2) and 8x8(4).
- It sits between the macroblock scheduler (start/done) and the SAD array and BRAMs.

---
 rtl/me_search_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_me_search_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/me_search_ctrl.sv
// Purpose : full-window motion-search sequencer for one 16x16 MB over the VBS SAD array; tracks best SAD/MV for 9 partitions.
// Latency : (PEY+PIPE_LAT+3) cycles per candidate, 4*SR*SR candidates, plus 1 DONE cycle; done pulses when results are final.
// Backpressure : none; start is accepted only in IDLE, and the array/BRAMs are assumed always ready.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset (aborts any search, no done)
//   start, ref_base           begin search; ref row address of candidate (-SR,-SR) top row
//   sel                       array control: 00 hold, 01 load row, 10 compute
//   curr_addr, ref_addr       current-MB / reference BRAM row addresses (valid while sel=01)
//   ref_col                   signed mvx for the reference column mux (valid while sel=01)
//   sad_in                    9 partition SADs: 0=16x16, 1-2=16x8, 3-4=8x16, 5-8=8x8
//   et_thresh                 early-termination threshold, used only with ME_EARLY_TERM_EN
//   busy, done                search in progress / one-cycle completion pulse
//   best_sad, best_mvx/mvy    per-partition minimum SAD and the MV that produced it
// Optional feature macro: ME_EARLY_TERM_EN (stop once best 16x16 SAD drops below et_thresh).
module me_search_ctrl #(
    parameter int SR         = 8,
    parameter int PEY        = 16,
    parameter int SAD_WIDTH  = 16,
    parameter int MV_WIDTH   = 6,
    parameter int PIPE_LAT   = 3,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     ref_base,
    output logic [1:0]                sel,
    output logic [ADDR_WIDTH-1:0]     curr_addr,
    output logic [ADDR_WIDTH-1:0]     ref_addr,
    output logic [MV_WIDTH-1:0]       ref_col,
    input  logic [9*SAD_WIDTH-1:0]    sad_in,
    input  logic [SAD_WIDTH-1:0]      et_thresh,
    output logic                      busy,
    output logic                      done,
    output logic [9*SAD_WIDTH-1:0]    best_sad,
    output logic [9*MV_WIDTH-1:0]     best_mvx,
    output logic [9*MV_WIDTH-1:0]     best_mvy
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_CMP, S_NEXT, S_DONE
    } state_t;

    // One counter serves both the LOAD row index and the DRAIN wait.
    localparam int CNT_W = $clog2((PEY > PIPE_LAT ? PEY : PIPE_LAT) + 1);
    localparam logic [CNT_W-1:0]    LOAD_LAST  = CNT_W'(PEY - 1);
    localparam logic [CNT_W-1:0]    DRAIN_LAST = CNT_W'(PIPE_LAT - 1);
    localparam logic [MV_WIDTH-1:0] MV_MIN     = MV_WIDTH'(-SR);
    localparam logic [MV_WIDTH-1:0] MV_MAX     = MV_WIDTH'(SR - 1);
    localparam logic [MV_WIDTH-1:0] MV_BIAS    = MV_WIDTH'(SR);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [MV_WIDTH-1:0]     mvx_q, mvx_d, mvy_q, mvy_d;
    logic [ADDR_WIDTH-1:0]   ref_base_q, ref_base_d;
    logic [SAD_WIDTH-1:0]    best_sad_q [9];
    logic [SAD_WIDTH-1:0]    best_sad_d [9];
    logic [MV_WIDTH-1:0]     best_mvx_q [9];
    logic [MV_WIDTH-1:0]     best_mvx_d [9];
    logic [MV_WIDTH-1:0]     best_mvy_q [9];
    logic [MV_WIDTH-1:0]     best_mvy_d [9];
    logic [SAD_WIDTH-1:0]    sad_p      [9];
    logic [8:0]              upd;
    logic [SAD_WIDTH-1:0]    new_best0;
    logic [MV_WIDTH-1:0]     y_off;

    // mvy+SR is the non-negative row offset of this candidate inside the window.
    assign y_off     = mvy_q + MV_BIAS;
    assign new_best0 = upd[0] ? sad_p[0] : best_sad_q[0];

    for (genvar p = 0; p < 9; p++) begin : g_part
        assign sad_p[p] = sad_in[p*SAD_WIDTH +: SAD_WIDTH];
        // Strict compare: ties keep the earlier candidate in raster order.
        assign upd[p]   = sad_p[p] < best_sad_q[p];
        assign best_sad[p*SAD_WIDTH +: SAD_WIDTH] = best_sad_q[p];
        assign best_mvx[p*MV_WIDTH  +: MV_WIDTH]  = best_mvx_q[p];
        assign best_mvy[p*MV_WIDTH  +: MV_WIDTH]  = best_mvy_q[p];
    end

`ifndef ME_EARLY_TERM_EN
    logic unused_et;
    assign unused_et = ^et_thresh;
`endif

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_LOAD;
            S_LOAD:    if (cnt_q == LOAD_LAST) state_d = S_COMPUTE;
            S_COMPUTE: state_d = S_DRAIN;
            S_DRAIN:   if (cnt_q == DRAIN_LAST) state_d = S_CMP;
            S_CMP: begin
`ifdef ME_EARLY_TERM_EN
                if (new_best0 < et_thresh) state_d = S_DONE;
                else                       state_d = S_NEXT;
`else
                state_d = S_NEXT;
`endif
            end
            S_NEXT:    state_d = (mvx_q == MV_MAX && mvy_q == MV_MAX) ? S_DONE : S_LOAD;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        sel       = 2'b00;
        curr_addr = '0;
        ref_addr  = '0;
        ref_col   = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_LOAD: begin
                sel       = 2'b01;
                curr_addr = ADDR_WIDTH'(cnt_q);
                ref_addr  = ref_base_q + ADDR_WIDTH'(y_off) + ADDR_WIDTH'(cnt_q);
                ref_col   = mvx_q;
                busy      = 1'b1;
            end
            S_COMPUTE: begin
                sel  = 2'b10;
                busy = 1'b1;
            end
            S_DRAIN, S_CMP, S_NEXT: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values
    always_comb begin
        cnt_d      = cnt_q;
        mvx_d      = mvx_q;
        mvy_d      = mvy_q;
        ref_base_d = ref_base_q;
        best_sad_d = best_sad_q;
        best_mvx_d = best_mvx_q;
        best_mvy_d = best_mvy_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ref_base_d = ref_base;
                    mvx_d      = MV_MIN;
                    mvy_d      = MV_MIN;
                    cnt_d      = '0;
                    for (int p = 0; p < 9; p++) best_sad_d[p] = '1;
                end
            end
            S_LOAD:  cnt_d = (cnt_q == LOAD_LAST)  ? '0 : cnt_q + 1'b1;
            S_DRAIN: cnt_d = (cnt_q == DRAIN_LAST) ? '0 : cnt_q + 1'b1;
            S_CMP: begin
                for (int p = 0; p < 9; p++) begin
                    if (upd[p]) begin
                        best_sad_d[p] = sad_p[p];
                        best_mvx_d[p] = mvx_q;
                        best_mvy_d[p] = mvy_q;
                    end
                end
            end
            S_NEXT: begin
                if (mvx_q == MV_MAX) begin
                    mvx_d = MV_MIN;
                    mvy_d = (mvy_q == MV_MAX) ? MV_MIN : mvy_q + 1'b1;
                end else begin
                    mvx_d = mvx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            mvx_q      <= MV_MIN;
            mvy_q      <= MV_MIN;
            ref_base_q <= '0;
            for (int p = 0; p < 9; p++) begin
                best_sad_q[p] <= '1;
                best_mvx_q[p] <= '0;
                best_mvy_q[p] <= '0;
            end
        end else begin
            cnt_q      <= cnt_d;
            mvx_q      <= mvx_d;
            mvy_q      <= mvy_d;
            ref_base_q <= ref_base_d;
            best_sad_q <= best_sad_d;
            best_mvx_q <= best_mvx_d;
            best_mvy_q <= best_mvy_d;
        end
    end

endmodule

// File: tb/tb_me_search_ctrl.sv
// Purpose : self-checking bench for me_search_ctrl with SR=2, PEY=16, PIPE_LAT=3.
// Latency : expects done 1+N*(PEY+PIPE_LAT+3) cycles after the start cycle.
// Backpressure : none; the bench plays the SAD array and answers each compute strobe.
module tb_me_search_ctrl;
    localparam int SR    = 2;
    localparam int PEY   = 16;
    localparam int SW    = 16;
    localparam int MW    = 6;
    localparam int PL    = 3;
    localparam int AW    = 10;
    localparam int NCAND = 4 * SR * SR;
    localparam int PER   = PEY + PL + 3;

    typedef struct packed {
        logic [31:0]        cyc;
        logic [8:0][SW-1:0] sad;
        logic [8:0][MW-1:0] mx;
        logic [8:0][MW-1:0] my;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [AW-1:0]   ref_base = '0;
    logic [1:0]      sel;
    logic [AW-1:0]   curr_addr, ref_addr;
    logic [MW-1:0]   ref_col;
    logic [9*SW-1:0] sad_in = '0;
    logic [SW-1:0]   et_thresh = '0;
    logic            busy, done;
    logic [9*SW-1:0] best_sad;
    logic [9*MW-1:0] best_mvx, best_mvy;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t scb[$];

    me_search_ctrl #(.SR(SR), .PEY(PEY), .SAD_WIDTH(SW), .MV_WIDTH(MW),
                     .PIPE_LAT(PL), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .ref_base(ref_base), .sel(sel),
        .curr_addr(curr_addr), .ref_addr(ref_addr), .ref_col(ref_col),
        .sad_in(sad_in), .et_thresh(et_thresh), .busy(busy), .done(done),
        .best_sad(best_sad), .best_mvx(best_mvx), .best_mvy(best_mvy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SAD patterns the bench array returns per test and candidate.
    function automatic int sad_of(int tid, int p, int mx, int my);
        case (tid)
            1: return (p == 0 && mx == 1 && my == -2) ? 20 : 100;
            2: return (p == 0 && ((mx == -2 && my == -2) || (mx == 0 && my == 1))) ? 50 : 80;
            3: begin
                if (p == 5) return (mx == -1 && my == 0) ? 7 : 60;
                if (p == 2) return (mx == 1 && my == 1) ? 9 : 60;
                return 200 - ((mx + SR) + (my + SR) * 2 * SR);
            end
            4: return (p == 0 && mx == 0 && my == -2) ? 5 : 100;
            default: return 100;
        endcase
    endfunction

    function automatic exp_t model(int tid, logic [SW-1:0] thr);
        exp_t e;
        int   v;
        e.sad = '1;
        e.mx  = '0;
        e.my  = '0;
        e.cyc = 1;
        for (int k = 0; k < NCAND; k++) begin
            int mx = -SR + k % (2 * SR);
            int my = -SR + k / (2 * SR);
            e.cyc = e.cyc + PER;
            for (int p = 0; p < 9; p++) begin
                v = sad_of(tid, p, mx, my);
                if (v < int'(e.sad[p])) begin
                    e.sad[p] = SW'(v);
                    e.mx[p]  = MW'(mx);
                    e.my[p]  = MW'(my);
                end
            end
`ifdef ME_EARLY_TERM_EN
            if (e.sad[0] < thr) break;
`else
            if (thr != thr) break;
`endif
        end
        return e;
    endfunction

    // Runs one search from a negedge; poke_cyc>0 pulses start while busy.
    task automatic run_search(input int tid, input logic [AW-1:0] base, input int poke_cyc);
        exp_t          e;
        int            cyc = 1;
        int            k = 0;
        int            r = 0;
        int            mx, my;
        logic [MW-1:0] mxv;
        logic [AW-1:0] ea;
        scb.push_back(model(tid, et_thresh));
        ref_base = base;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        ref_base = ~base;
        while (cyc < 2000) begin
            mx = -SR + k % (2 * SR);
            my = -SR + k / (2 * SR);
            if (sel == 2'b01) begin
                if (base == 10'd100 && mx == 0 && my == -1) begin
                    ea  = base + AW'(my + SR + r);
                    mxv = MW'(mx);
                    chk("ref_addr", 32'(ref_addr), 32'(ea));
                    chk("curr_addr", 32'(curr_addr), r);
                    chk("ref_col", 32'(ref_col), 32'(mxv));
                end
                r++;
            end else if (sel == 2'b10) begin
                chk("rows_before_compute", r, PEY);
                for (int p = 0; p < 9; p++) sad_in[p*SW +: SW] = SW'(sad_of(tid, p, mx, my));
                k++;
                r = 0;
            end
            if (done) break;
            start = (poke_cyc > 0 && cyc == poke_cyc);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        e = scb.pop_front();
        chk("done_seen", 32'(done), 1);
        chk("done_cycle", cyc, e.cyc);
        chk("candidates", k, (e.cyc - 1) / PER);
        chk("busy_at_done", 32'(busy), 0);
        for (int p = 0; p < 9; p++) begin
            chk($sformatf("t%0d_sad%0d", tid, p), 32'(best_sad[p*SW +: SW]), 32'(e.sad[p]));
            chk($sformatf("t%0d_mvx%0d", tid, p), 32'(best_mvx[p*MW +: MW]), 32'(e.mx[p]));
            chk($sformatf("t%0d_mvy%0d", tid, p), 32'(best_mvy[p*MW +: MW]), 32'(e.my[p]));
        end
        // start during the DONE cycle must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("idle_sel", 32'(sel), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
        @(negedge clk);
        chk("still_idle", 32'(sel), 0);
    endtask

    initial begin
        int n_done;
        logic [MW-1:0] mv1;
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ref_addr", 32'(ref_addr), 0);
        chk("rst_best_sad_ones", 32'(&best_sad), 1);
        chk("rst_best_mvx", 32'(|best_mvx), 0);
        rst = 1'b0;
        @(negedge clk);

        // full search, single 16x16 minimum, address sequence at (0,-1)
        run_search(1, 10'd100, 0);
        mv1 = MW'(1);
        chk("t1_fixed_mvx0", 32'(best_mvx[MW-1:0]), 32'(mv1));

        // reset mid-LOAD aborts without done
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("midload_sel", 32'(sel), 1);
        rst = 1'b1;
        #1;
        chk("abort_sel", 32'(sel), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_best_sad0", 32'(best_sad[SW-1:0]), 32'hFFFF);
        chk("abort_best_mvx", 32'(|best_mvx), 0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        chk("no_done_after_abort", n_done, 0);

        // tie rule, with a start pulse while busy
        run_search(2, 10'd7, 100);
        // independent partitions, address wraps near the top of the BRAM
        run_search(3, 10'h3FC, 0);
`ifdef ME_EARLY_TERM_EN
        et_thresh = 16'd10;
        run_search(4, 10'd0, 30);
        et_thresh = '0;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
